// File: rtl/passcode_entry_controller_if.sv
// Keypad key channel plus lock comparator code channel for passcode_entry_controller.
// master: the controller; slave: keypad scanner / lock comparator side.
interface passcode_entry_controller_if;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_ready;
    logic [3:0] digit1;
    logic [3:0] digit2;
    logic [3:0] digit3;
    logic [3:0] digit4;
    logic       code_valid;
    logic       unlocked;

    modport master (
        input  key_valid,
        input  key_code,
        input  unlocked,
        output key_ready,
        output digit1,
        output digit2,
        output digit3,
        output digit4,
        output code_valid
    );

    modport slave (
        output key_valid,
        output key_code,
        output unlocked,
        input  key_ready,
        input  digit1,
        input  digit2,
        input  digit3,
        input  digit4,
        input  code_valid
    );
endinterface

// File: rtl/passcode_entry_controller.sv
// Assembles four keypad digits into a code, strobes it to the lock comparator,
// samples the unlocked result and reports pass/fail.
// Optional feature macro: PASSCODE_LOCKOUT_EN (adds the LOCKOUT state after
// MAX_FAILS consecutive failures; otherwise locked_out is tied low and the fail
// counter saturates).
module passcode_entry_controller #(
    parameter int unsigned RESULT_LATENCY = 1,
    parameter int unsigned MAX_FAILS      = 3,
    parameter int unsigned LOCKOUT_CYCLES = 100
) (
    input  logic                         clk,
    input  logic                         reset,
    passcode_entry_controller_if.master  bus,
    output logic [2:0]                   entry_count,
    output logic                         pass,
    output logic                         fail,
    output logic                         locked_out
);

    localparam int unsigned LAT_W     = (RESULT_LATENCY > 1) ? $clog2(RESULT_LATENCY) : 1;
    localparam int unsigned CNT_W     = 3;
    localparam int unsigned FAIL_W    = 3;
    localparam logic [3:0]  KEY_CLEAR = 4'hA;
    localparam logic [3:0]  KEY_BKSP  = 4'hB;

    typedef enum logic [1:0] {
        COLLECT,
        SUBMIT,
        CHECK
`ifdef PASSCODE_LOCKOUT_EN
        , LOCKOUT
`endif
    } state_t;

    // Out-of-range parameters are an elaboration error.
    if (RESULT_LATENCY == 0 || MAX_FAILS == 0 || MAX_FAILS > 7 || LOCKOUT_CYCLES == 0) begin : g_bad_params
        $error("passcode_entry_controller: parameter out of range");
    end

    state_t              state_q, state_d;
    logic [3:0]          digit_q [4];
    logic [3:0]          digit_d [4];
    logic [CNT_W-1:0]    count_d;
    logic [FAIL_W-1:0]   fail_cnt_q, fail_cnt_d, fail_inc;
    logic [LAT_W-1:0]    lat_q, lat_d;
    logic                pass_d, fail_d;
    logic                key_xfer;

`ifdef PASSCODE_LOCKOUT_EN
    localparam int unsigned LO_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    logic [LO_W-1:0]     lo_q, lo_d;
`endif

    // Ready depends only on state and reset so the keypad never sees a combinational loop.
    assign bus.key_ready = (state_q == COLLECT) && !reset;
    assign key_xfer      = bus.key_valid && bus.key_ready;

    assign bus.digit1 = digit_q[0];
    assign bus.digit2 = digit_q[1];
    assign bus.digit3 = digit_q[2];
    assign bus.digit4 = digit_q[3];

    // Next-state and next-value logic for entry, submit, result check and lockout.
    always_comb begin
        state_d    = state_q;
        digit_d    = digit_q;
        count_d    = entry_count;
        fail_cnt_d = fail_cnt_q;
        lat_d      = lat_q;
        pass_d     = 1'b0;
        fail_d     = 1'b0;
        fail_inc   = fail_cnt_q + FAIL_W'(1);
`ifdef PASSCODE_LOCKOUT_EN
        lo_d       = lo_q;
`endif
        case (state_q)
            COLLECT: begin
                if (key_xfer) begin
                    if (bus.key_code <= 4'd9) begin
                        digit_d[entry_count[1:0]] = bus.key_code;
                        count_d = entry_count + CNT_W'(1);
                        if (entry_count == CNT_W'(3)) begin
                            state_d = SUBMIT;
                        end
                    end else if (bus.key_code == KEY_CLEAR) begin
                        digit_d = '{default: 4'h0};
                        count_d = '0;
                    end else if (bus.key_code == KEY_BKSP && entry_count != '0) begin
                        digit_d[2'(entry_count - CNT_W'(1))] = 4'h0;
                        count_d = entry_count - CNT_W'(1);
                    end
                end
            end
            SUBMIT: begin
                state_d = CHECK;
                lat_d   = '0;
            end
            CHECK: begin
                if (lat_q == LAT_W'(RESULT_LATENCY - 1)) begin
                    digit_d = '{default: 4'h0};
                    count_d = '0;
                    state_d = COLLECT;
                    if (bus.unlocked) begin
                        pass_d     = 1'b1;
                        fail_cnt_d = '0;
                    end else begin
                        fail_d = 1'b1;
`ifdef PASSCODE_LOCKOUT_EN
                        fail_cnt_d = fail_inc;
                        if (fail_inc == FAIL_W'(MAX_FAILS)) begin
                            state_d = LOCKOUT;
                            lo_d    = '0;
                        end
`else
                        if (fail_cnt_q != FAIL_W'(MAX_FAILS)) begin
                            fail_cnt_d = fail_inc;
                        end
`endif
                    end
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
`ifdef PASSCODE_LOCKOUT_EN
            LOCKOUT: begin
                if (lo_q == LO_W'(LOCKOUT_CYCLES - 1)) begin
                    state_d    = COLLECT;
                    fail_cnt_d = '0;
                end else begin
                    lo_d = lo_q + LO_W'(1);
                end
            end
`endif
            default: state_d = COLLECT;
        endcase
    end

    // State and datapath registers; reset drops any pending strobe or pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= COLLECT;
            digit_q        <= '{default: 4'h0};
            entry_count    <= '0;
            fail_cnt_q     <= '0;
            lat_q          <= '0;
            pass           <= 1'b0;
            fail           <= 1'b0;
            bus.code_valid <= 1'b0;
        end else begin
            state_q        <= state_d;
            digit_q        <= digit_d;
            entry_count    <= count_d;
            fail_cnt_q     <= fail_cnt_d;
            lat_q          <= lat_d;
            pass           <= pass_d;
            fail           <= fail_d;
            bus.code_valid <= (state_d == SUBMIT);
        end
    end

`ifdef PASSCODE_LOCKOUT_EN
    // Lockout timer and registered lockout indication.
    always_ff @(posedge clk) begin
        if (reset) begin
            lo_q       <= '0;
            locked_out <= 1'b0;
        end else begin
            lo_q       <= lo_d;
            locked_out <= (state_d == LOCKOUT);
        end
    end
`else
    assign locked_out = 1'b0;
`endif

endmodule
